debounce_multi: RTL and testbench

Parametrised multi-channel debouncer for buttons, switches and strap inputs.
- Each channel has its own synchroniser, stability counter, debounced level, and separate rising/falling event pulses.
- Replaces per-button single-channel debounce instances in the top level and feeds UI/menu FSMs directly.
- Optional auto-repeat for held buttons, compiled in by macro.

---
 rtl/debounce_multi.sv | 134 +++++++++++++
 tb/tb_debounce_multi.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser, stability counter, level and edge pulses.
// Optional auto-repeat for held channels is compiled in with `define DEBOUNCE_REPEAT_EN.
module debounce_multi #(
  parameter int p_channels      = 4,
  parameter int p_sync_stages   = 3,
  parameter int p_min_on        = 1000,
  parameter int p_repeat_delay  = 50000000,
  parameter int p_repeat_period = 10000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [p_channels-1:0] i_trig,
  output logic [p_channels-1:0] o_state,
  output logic [p_channels-1:0] o_rise,
  output logic [p_channels-1:0] o_fall,
  output logic                  o_any_rise,
  output logic [p_channels-1:0] o_repeat
);

  localparam int CW = $clog2(p_min_on + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(p_min_on - 1);

  if (p_channels < 1) begin : g_chk_channels
    $error("p_channels must be at least 1");
  end
  if (p_sync_stages < 2) begin : g_chk_sync
    $error("p_sync_stages must be at least 2");
  end
  if (p_min_on < 1) begin : g_chk_min_on
    $error("p_min_on must be at least 1");
  end
  if (p_repeat_delay < 1 || p_repeat_period < 1) begin : g_chk_repeat
    $error("p_repeat_delay and p_repeat_period must be at least 1");
  end

  logic [p_channels-1:0][p_sync_stages-1:0] sync_p0;
  logic [p_channels-1:0][CW-1:0]            cnt_p1, cnt_nxt;
  logic [p_channels-1:0]                    sync_s, state_nxt, rise_nxt, fall_nxt;

  // Stage 0: synchroniser shift registers; the last flop is the synchronised level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_p0 <= '0;
    end else begin
      for (int ch = 0; ch < p_channels; ch++) begin
        sync_p0[ch] <= {sync_p0[ch][p_sync_stages-2:0], i_trig[ch]};
      end
    end
  end

  always_comb begin
    sync_s    = '0;
    state_nxt = o_state;
    rise_nxt  = '0;
    fall_nxt  = '0;
    cnt_nxt   = cnt_p1;
    for (int ch = 0; ch < p_channels; ch++) begin
      sync_s[ch] = sync_p0[ch][p_sync_stages-1];
      if (sync_s[ch] == o_state[ch]) begin
        cnt_nxt[ch] = '0;
      end else if (cnt_p1[ch] == CNT_LAST) begin
        cnt_nxt[ch]   = '0;
        state_nxt[ch] = sync_s[ch];
        rise_nxt[ch]  = sync_s[ch];
        fall_nxt[ch]  = ~sync_s[ch];
      end else begin
        // Increment only below p_min_on-1, so the counter cannot wrap
        cnt_nxt[ch] = cnt_p1[ch] + CW'(1);
      end
    end
  end

  // Stage 1: stability counters, debounced level and edge pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_p1     <= '0;
      o_state    <= '0;
      o_rise     <= '0;
      o_fall     <= '0;
      o_any_rise <= 1'b0;
    end else begin
      cnt_p1     <= cnt_nxt;
      o_state    <= state_nxt;
      o_rise     <= rise_nxt;
      o_fall     <= fall_nxt;
      o_any_rise <= |rise_nxt;
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int HMAX = (p_repeat_delay > p_repeat_period) ? p_repeat_delay : p_repeat_period;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(p_repeat_delay - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(p_repeat_period - 1);

  logic [p_channels-1:0][HW-1:0] hold_p1, hold_nxt;
  logic [p_channels-1:0]         phase_p1, phase_nxt, rep_nxt;

  // phase_p1 marks that the first (delay) pulse has been issued; later pulses use the period
  always_comb begin
    hold_nxt  = hold_p1;
    phase_nxt = phase_p1;
    rep_nxt   = '0;
    for (int ch = 0; ch < p_channels; ch++) begin
      if (!o_state[ch] || rise_nxt[ch] || fall_nxt[ch]) begin
        hold_nxt[ch]  = '0;
        phase_nxt[ch] = 1'b0;
      end else if (hold_p1[ch] == (phase_p1[ch] ? PERIOD_LAST : DELAY_LAST)) begin
        hold_nxt[ch]  = '0;
        phase_nxt[ch] = 1'b1;
        rep_nxt[ch]   = 1'b1;
      end else begin
        hold_nxt[ch] = hold_p1[ch] + HW'(1);
      end
    end
  end

  // Stage 2: hold counters and repeat pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_p1  <= '0;
      phase_p1 <= '0;
      o_repeat <= '0;
    end else begin
      hold_p1  <= hold_nxt;
      phase_p1 <= phase_nxt;
      o_repeat <= rep_nxt;
    end
  end
`else
  assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: 2 channels, 3 sync stages, min_on 4, repeat 10/5.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] trig;
  logic [1:0] o_state, o_rise, o_fall, o_repeat;
  logic       o_any_rise;

  int cyc    = 0;
  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    int         cyc;
    logic [1:0] state;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] rep;
    logic       any;
  } ev_t;

  ev_t exp_q[$];

  debounce_multi #(
    .p_channels     (2),
    .p_sync_stages  (3),
    .p_min_on       (4),
    .p_repeat_delay (10),
    .p_repeat_period(5)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_trig    (trig),
    .o_state   (o_state),
    .o_rise    (o_rise),
    .o_fall    (o_fall),
    .o_any_rise(o_any_rise),
    .o_repeat  (o_repeat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any pulse output must match the oldest expected event
  always @(negedge clk) begin
    if ((o_rise | o_fall | o_repeat) != 2'b00 || o_any_rise) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b any=%b rep=%b, required no pulse",
                 cyc, o_rise, o_fall, o_any_rise, o_repeat);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.cyc == cyc && e.state == o_state && e.rise == o_rise && e.fall == o_fall &&
            e.rep == o_repeat && e.any == o_any_rise) begin
          n_pass++;
        end else begin
          $display("FAIL event got cyc=%0d state=%b rise=%b fall=%b any=%b rep=%b, required cyc=%0d state=%b rise=%b fall=%b any=%b rep=%b",
                   cyc, o_state, o_rise, o_fall, o_any_rise, o_repeat,
                   e.cyc, e.state, e.rise, e.fall, e.any, e.rep);
        end
      end
    end
  end

  task automatic push(input int c, input logic [1:0] st, input logic [1:0] ri,
                      input logic [1:0] fa, input logic [1:0] rp, input logic an);
    ev_t e;
    e.cyc = c; e.state = st; e.rise = ri; e.fall = fa; e.rep = rp; e.any = an;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  initial begin
    int c;
    int r;
    rst  = 1'b1;
    trig = 2'b00;
    step(3);
    chk("reset_state", int'(o_state), 0);
    chk("reset_rise", int'(o_rise), 0);
    chk("reset_fall", int'(o_fall), 0);
    chk("reset_any", int'(o_any_rise), 0);
    chk("reset_repeat", int'(o_repeat), 0);
    rst = 1'b0;
    step(2);

    // Press ch0: state changes on the 7th edge counting the sampling edge; then release
    c = cyc;
    trig = 2'b01;
    push(c + 7, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1);
    step(6);
    chk("press_before", int'(o_state), 0);
    step(1);
    chk("press_after", int'(o_state), 1);
    step(1);
    trig = 2'b00;
    push(c + 15, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    step(6);
    chk("release_before", int'(o_state), 1);
    step(1);
    chk("release_after", int'(o_state), 0);
    step(3);

    // Glitch of 3 cycles is rejected; 4 cycles is accepted
    trig = 2'b01;
    step(3);
    trig = 2'b00;
    step(12);
    chk("glitch3_state", int'(o_state), 0);
    c = cyc;
    trig = 2'b01;
    push(c + 7, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1);
    step(4);
    trig = 2'b00;
    push(c + 11, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    step(12);
    chk("pulse4_state", int'(o_state), 0);

    // Both channels together
    c = cyc;
    trig = 2'b11;
    push(c + 7, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1);
    step(7);
    chk("both_state", int'(o_state), 3);
    trig = 2'b00;
    push(c + 14, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    step(7);
    chk("both_release", int'(o_state), 0);
    step(3);

    // Ch1 chatters with period 2 while ch0 presses
    c = cyc;
    trig = 2'b01;
    push(c + 7, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      trig[1] = (i % 2 == 0);
      step(1);
    end
    trig = 2'b00;
    push(c + 15, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    step(10);
    chk("chatter_state", int'(o_state), 0);
    step(3);

    // Reset at counter=2 mid-press, then a long hold for auto-repeat
    c = cyc;
    trig = 2'b01;
    step(5);
    rst = 1'b1;
    step(1);
    chk("midrst_state", int'(o_state), 0);
    chk("midrst_pulses", int'({o_rise, o_fall, o_repeat, o_any_rise}), 0);
    rst = 1'b0;
    r = cyc + 7;
    push(r, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1);
`ifdef DEBOUNCE_REPEAT_EN
    push(r + 10, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
    push(r + 15, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
    push(r + 20, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
    push(r + 25, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
`endif
    step(6);
    chk("postrst_before", int'(o_state), 0);
    step(1);
    chk("postrst_after", int'(o_state), 1);
    step(23);
    trig = 2'b00;
    // Fall lands where a repeat would otherwise be due; no repeat in that cycle
    push(r + 30, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    step(7);
    chk("hold_release", int'(o_state), 0);
    step(12);
    chk("repeat_idle", int'(o_repeat), 0);
    chk("queue_drained", exp_q.size(), 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
